// File: rtl/snn_pkg.sv
// Shared types and defaults for the SNN layer timestep sequencer.
package snn_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SHIFT   = 3'd1,
    WAIT    = 3'd2,
    FIRE    = 3'd3,
    CAPTURE = 3'd4,
    OUT     = 3'd5
  } state_e;

  localparam int unsigned SETTLE_DEFAULT = 2;
  localparam int unsigned CNTW_DEFAULT   = 16;
  // Wide enough for SETTLE-1 with SETTLE up to 15.
  localparam int unsigned TIMER_W        = 4;

endpackage

// File: rtl/snn_pulse_timer.sv
// Loadable down-counter with a zero flag; times the settle gap after delay_clk.
module snn_pulse_timer
  import snn_pkg::*;
#(
  parameter int unsigned W = TIMER_W
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load_i,
  input  logic [W-1:0] value_i,
  input  logic         dec_i,
  output logic         done_c
);

  logic [W-1:0] count_q, count_d;

  // Load wins over decrement; the counter parks at zero.
  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = value_i;
    end else if (dec_i && (count_q != '0)) begin
      count_d = count_q - W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign done_c = (count_q == '0);

endmodule

// File: rtl/snn_layer_step_sequencer.sv
// Runs one SNN timestep: latch spikes, pulse delay_clk, settle, pulse enable,
// capture the layer result and hold it on a valid/ready output channel.
module snn_layer_step_sequencer
  import snn_pkg::*;
#(
  parameter int unsigned M      = 2,
  parameter int unsigned N      = 4,
  parameter int unsigned Nbits  = 4,
  parameter int unsigned SETTLE = SETTLE_DEFAULT,
  parameter int unsigned CNTW   = CNTW_DEFAULT
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [M-1:0]        in_spikes,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [N-1:0]        out_spikes,
  output logic [N*Nbits-1:0]  out_potentials,
  output logic [M-1:0]        layer_input_spikes,
  output logic                layer_delay_clk,
  output logic                layer_enable,
  input  logic [N-1:0]        layer_output_spikes,
  input  logic [N*Nbits-1:0]  layer_membrane,
  output logic                busy,
  output logic [CNTW-1:0]     step_count
);

  localparam int unsigned PW = N * Nbits;

  state_e          state_q, state_d;
  logic            in_ready_q, in_ready_d;
  logic            busy_q, busy_d;
  logic            out_valid_q, out_valid_d;
  logic [N-1:0]    out_spikes_q, out_spikes_d;
  logic [PW-1:0]   out_pot_q, out_pot_d;
  logic [M-1:0]    lin_q, lin_d;
  logic            dclk_q, dclk_d;
  logic            en_q, en_d;
  logic [CNTW-1:0] step_q, step_d;

  logic            timer_load;
  logic            timer_dec;
  logic            timer_done;

  snn_pulse_timer #(
    .W (TIMER_W)
  ) u_settle (
    .clk     (clk),
    .reset   (reset),
    .load_i  (timer_load),
    .value_i (TIMER_W'(SETTLE - 1)),
    .dec_i   (timer_dec),
    .done_c  (timer_done)
  );

  // Outputs are computed one state ahead so the pulses line up with their
  // states.
  always_comb begin
    state_d      = state_q;
    out_valid_d  = out_valid_q;
    out_spikes_d = out_spikes_q;
    out_pot_d    = out_pot_q;
    lin_d        = lin_q;
    step_d       = step_q;
    dclk_d       = 1'b0;
    en_d         = 1'b0;
    timer_load   = 1'b0;
    timer_dec    = 1'b0;

    case (state_q)
      IDLE: begin
        if (in_valid && in_ready_q) begin
          lin_d   = in_spikes;
          dclk_d  = 1'b1;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        timer_load = 1'b1;
        state_d    = WAIT;
      end
      WAIT: begin
        if (timer_done) begin
          en_d    = 1'b1;
          state_d = FIRE;
        end else begin
          timer_dec = 1'b1;
        end
      end
      FIRE: begin
        state_d = CAPTURE;
      end
      CAPTURE: begin
        // Layer state has absorbed the enable edge by now.
        out_spikes_d = layer_output_spikes;
        out_pot_d    = layer_membrane;
        out_valid_d  = 1'b1;
        state_d      = OUT;
      end
      OUT: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          step_d      = step_q + CNTW'(1);
          state_d     = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    in_ready_d = (state_d == IDLE);
    busy_d     = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      in_ready_q   <= 1'b1;
      busy_q       <= 1'b0;
      out_valid_q  <= 1'b0;
      out_spikes_q <= '0;
      out_pot_q    <= '0;
      lin_q        <= '0;
      dclk_q       <= 1'b0;
      en_q         <= 1'b0;
      step_q       <= '0;
    end else begin
      state_q      <= state_d;
      in_ready_q   <= in_ready_d;
      busy_q       <= busy_d;
      out_valid_q  <= out_valid_d;
      out_spikes_q <= out_spikes_d;
      out_pot_q    <= out_pot_d;
      lin_q        <= lin_d;
      dclk_q       <= dclk_d;
      en_q         <= en_d;
      step_q       <= step_d;
    end
  end

  assign in_ready           = in_ready_q;
  assign busy               = busy_q;
  assign out_valid          = out_valid_q;
  assign out_spikes         = out_spikes_q;
  assign out_potentials     = out_pot_q;
  assign layer_input_spikes = lin_q;
  assign layer_delay_clk    = dclk_q;
  assign layer_enable       = en_q;
  assign step_count         = step_q;

endmodule

// File: tb/tb_snn_layer_step_sequencer.sv
// Directed bench: default build against a toy layer, plus SETTLE=1 and
// SETTLE=15/CNTW=4 builds for pulse spacing and counter wrap.
module tb_snn_layer_step_sequencer;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  // Default build
  logic        in_valid, in_ready, out_valid, out_ready, busy, dclk, en;
  logic [1:0]  in_spikes, lin;
  logic [3:0]  out_spikes, lay_spk;
  logic [15:0] out_pot, lay_mem, step_count;

  // SETTLE=1 build
  logic        a_iv, a_ir, a_ov, a_or, a_busy, a_dclk, a_en;
  logic [1:0]  a_is, a_lin;
  logic [3:0]  a_os;
  logic [15:0] a_op, a_sc;

  // SETTLE=15, CNTW=4 build
  logic        b_iv, b_ir, b_ov, b_or, b_busy, b_dclk, b_en;
  logic [1:0]  b_is, b_lin;
  logic [3:0]  b_os, b_sc;
  logic [15:0] b_op;

  snn_layer_step_sequencer #(.M(2), .N(4), .Nbits(4), .SETTLE(2), .CNTW(16)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_spikes(in_spikes), .out_valid(out_valid), .out_ready(out_ready),
    .out_spikes(out_spikes), .out_potentials(out_pot),
    .layer_input_spikes(lin), .layer_delay_clk(dclk), .layer_enable(en),
    .layer_output_spikes(lay_spk), .layer_membrane(lay_mem),
    .busy(busy), .step_count(step_count)
  );

  snn_layer_step_sequencer #(.M(2), .N(4), .Nbits(4), .SETTLE(1), .CNTW(16)) dut_s1 (
    .clk(clk), .reset(reset), .in_valid(a_iv), .in_ready(a_ir),
    .in_spikes(a_is), .out_valid(a_ov), .out_ready(a_or),
    .out_spikes(a_os), .out_potentials(a_op),
    .layer_input_spikes(a_lin), .layer_delay_clk(a_dclk), .layer_enable(a_en),
    .layer_output_spikes(4'b0101), .layer_membrane(16'h00ff),
    .busy(a_busy), .step_count(a_sc)
  );

  snn_layer_step_sequencer #(.M(2), .N(4), .Nbits(4), .SETTLE(15), .CNTW(4)) dut_s15 (
    .clk(clk), .reset(reset), .in_valid(b_iv), .in_ready(b_ir),
    .in_spikes(b_is), .out_valid(b_ov), .out_ready(b_or),
    .out_spikes(b_os), .out_potentials(b_op),
    .layer_input_spikes(b_lin), .layer_delay_clk(b_dclk), .layer_enable(b_en),
    .layer_output_spikes(4'b1010), .layer_membrane(16'hff00),
    .busy(b_busy), .step_count(b_sc)
  );

  // Toy layer: each enable shifts the input spikes into the spike word and
  // adds a fixed step to the potentials.
  always @(posedge clk) begin
    if (reset) begin
      lay_spk <= 4'b0;
      lay_mem <= 16'h0;
    end else if (en) begin
      lay_spk <= {lay_spk[1:0], lin};
      lay_mem <= lay_mem + 16'h1234;
    end
  end

  // Pulse statistics, sampled on the cycle that ends at this edge.
  int cyc = 0, overlap = 0, en_cnt = 0;
  int a_t = 0, a_gap = 0, b_t = 0, b_gap = 0;
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (dclk && en) overlap <= overlap + 1;
    if (en) en_cnt <= en_cnt + 1;
    if (a_dclk) a_t <= cyc;
    if (a_en) a_gap <= cyc - a_t;
    if (b_dclk) b_t <= cyc;
    if (b_en) b_gap <= cyc - b_t;
  end

  int n_cmp = 0;
  int n_mis = 0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  logic [3:0] exp_tr [7];
  int t, n, hs, bad, en_before;
  int acc [3];

  initial begin
    exp_tr = '{4'b1000, 4'b0000, 4'b0000, 4'b0100, 4'b0000, 4'b0010, 4'b0001};
    reset = 1'b1;
    in_valid = 1'b0; in_spikes = 2'b00; out_ready = 1'b0;
    a_iv = 1'b0; a_is = 2'b00; a_or = 1'b0;
    b_iv = 1'b0; b_is = 2'b00; b_or = 1'b0;
    repeat (3) @(negedge clk);

    // Reset state
    check_eq("rst_flags", 64'({in_ready, out_valid, dclk, en, busy}), 64'(5'b10000));
    check_eq("rst_step_count", 64'(step_count), 64'(0));
    check_eq("rst_data", 64'({lin, out_spikes, out_pot}), 64'(0));
    reset = 1'b0;

    // Single step: {delay_clk, enable, out_valid, in_ready} per cycle
    in_spikes = 2'b01; in_valid = 1'b1; out_ready = 1'b1;
    for (int c = 1; c <= 7; c++) begin
      @(negedge clk);
      if (c == 1) in_valid = 1'b0;
      check_eq($sformatf("step1_trace_c%0d", c), 64'({dclk, en, out_valid, in_ready}), 64'(exp_tr[c-1]));
      if (c == 3) check_eq("step1_busy_wait", 64'(busy), 64'(1));
      if (c == 6) begin
        check_eq("step1_out_spikes", 64'(out_spikes), 64'(4'b0001));
        check_eq("step1_out_pot", 64'(out_pot), 64'(16'h1234));
      end
    end
    check_eq("step1_step_count", 64'(step_count), 64'(1));
    check_eq("step1_busy_idle", 64'(busy), 64'(0));

    // Backpressure
    in_spikes = 2'b10; in_valid = 1'b1; out_ready = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    t = 1;
    while (!out_valid && t < 20) begin @(negedge clk); t++; end
    check_eq("bp_out_valid_latency", 64'(t), 64'(6));
    check_eq("bp_out_spikes", 64'(out_spikes), 64'(4'b0110));
    check_eq("bp_out_pot", 64'(out_pot), 64'(16'h2468));
    in_valid = 1'b1; in_spikes = 2'b11;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_spikes !== 4'b0110 ||
          out_pot !== 16'h2468 || lin !== 2'b10) bad++;
    end
    check_eq("bp_hold_cycles_bad", 64'(bad), 64'(0));
    in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    check_eq("bp_release_flags", 64'({out_valid, in_ready}), 64'(2'b01));
    check_eq("bp_step_count", 64'(step_count), 64'(2));

    // Back-to-back with in_valid held high
    in_spikes = 2'b11; in_valid = 1'b1;
    t = 0; n = 0;
    while (n < 3 && t < 60) begin
      if (in_ready) begin acc[n] = t; n++; end
      @(negedge clk); t++;
    end
    in_valid = 1'b0;
    check_eq("b2b_accepts", 64'(n), 64'(3));
    check_eq("b2b_period_1", 64'(acc[1] - acc[0]), 64'(7));
    check_eq("b2b_period_2", 64'(acc[2] - acc[1]), 64'(7));
    t = 0;
    while (!in_ready && t < 20) begin @(negedge clk); t++; end
    check_eq("b2b_step_count", 64'(step_count), 64'(5));
    check_eq("b2b_out_spikes", 64'(out_spikes), 64'(4'b1111));
    check_eq("b2b_out_pot", 64'(out_pot), 64'(16'h5b04));
    check_eq("b2b_overlap", 64'(overlap), 64'(0));
    check_eq("b2b_enable_pulses", 64'(en_cnt), 64'(5));

    // Reset during WAIT
    in_spikes = 2'b01; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    check_eq("rw_busy_before", 64'(busy), 64'(1));
    en_before = en_cnt;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check_eq("rw_flags", 64'({in_ready, out_valid, dclk, en, busy}), 64'(5'b10000));
    check_eq("rw_data", 64'({lin, out_spikes, out_pot}), 64'(0));
    check_eq("rw_step_count", 64'(step_count), 64'(0));
    repeat (8) @(negedge clk);
    check_eq("rw_no_enable", 64'(en_cnt), 64'(en_before));
    check_eq("rw_idle", 64'({busy, in_ready}), 64'(2'b01));

    // SETTLE=1 build
    a_is = 2'b10; a_iv = 1'b1; a_or = 1'b1;
    @(negedge clk);
    a_iv = 1'b0;
    t = 1;
    while (!a_ov && t < 20) begin @(negedge clk); t++; end
    check_eq("s1_out_valid_latency", 64'(t), 64'(5));
    check_eq("s1_out_spikes", 64'(a_os), 64'(4'b0101));
    @(negedge clk);
    check_eq("s1_enable_gap", 64'(a_gap), 64'(2));
    check_eq("s1_step_count", 64'(a_sc), 64'(1));

    // SETTLE=15, CNTW=4: 17 steps wrap the counter to 1
    b_is = 2'b01; b_iv = 1'b1; b_or = 1'b1;
    hs = 0; t = 0;
    while (hs < 17 && t < 400) begin
      @(negedge clk); t++;
      if (b_ov && b_or) begin
        hs++;
        if (hs == 17) b_iv = 1'b0;
      end
    end
    check_eq("s15_handshakes", 64'(hs), 64'(17));
    @(negedge clk);
    check_eq("s15_enable_gap", 64'(b_gap), 64'(16));
    check_eq("s15_step_count_wrap", 64'(b_sc), 64'(1));
    check_eq("s15_idle", 64'({b_busy, b_ir}), 64'(2'b01));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
